// File: rtl/fake_cd_responder.sv
// CD-ROM drive emulation with no medium: every command ends in a status byte,
// REQUEST SENSE and INQUIRY additionally stream their data bytes to the bridge.
module fake_cd_responder #(
  parameter int         SENSE_LEN = 18,
  parameter int         INQ_LEN   = 36,
  parameter int         BYTE_GAP  = 0,
  parameter int         UNIT_ATTN = 1,
  parameter logic [7:0] NR_ASC    = 8'h3A
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic [95:0] COMMAND,
  input  logic        COMM_SEND,
  input  logic        CD_RDY,
  output logic        STAT_GET,
  output logic [7:0]  STATUS,
  output logic [7:0]  CD_DATA,
  output logic        CD_WR,
  output logic        BUSY
);

  typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, GAP, STAT} state_t;

  localparam logic [7:0] OP_SENSE = 8'h03;
  localparam logic [7:0] OP_INQ   = 8'h12;

  state_t     state;
  logic [5:0] idx;
  logic [7:0] cnt;
  logic [3:0] gap_cnt;
  logic       is_sense;
  logic       ua_pend;
  logic       ua_clr;

  logic [7:0] opcode;
  logic [7:0] alloc;
  logic [7:0] sense_cnt;
  logic [7:0] inq_cnt;
  logic [7:0] req_cnt;
  logic       is_data_op;
  logic       last_byte;
  logic       all_sent;
  logic       unused_cmd;

  function automatic logic [7:0] data_byte(input logic sense, input logic ua,
                                           input logic [5:0] i);
    logic [7:0] b;
    if (sense) begin
      case (i)
        6'd0:    b = 8'h70;
        6'd2:    b = ua ? 8'h06 : 8'h02;
        6'd7:    b = 8'(SENSE_LEN - 8);
        6'd12:   b = ua ? 8'h29 : NR_ASC;
        default: b = 8'h00;
      endcase
    end else begin
      case (i)
        6'd0:                b = 8'h05;
        6'd1:                b = 8'h80;
        6'd2, 6'd3:          b = 8'h02;
        6'd4:                b = 8'(INQ_LEN - 5);
        6'd5, 6'd6, 6'd7:    b = 8'h00;
        default:             b = 8'h20;
      endcase
    end
    return b;
  endfunction

  assign opcode     = COMMAND[7:0];
  assign alloc      = COMMAND[39:32];
  assign sense_cnt  = (alloc < 8'(SENSE_LEN)) ? alloc : 8'(SENSE_LEN);
  assign inq_cnt    = (alloc < 8'(INQ_LEN)) ? alloc : 8'(INQ_LEN);
  assign is_data_op = (opcode == OP_SENSE) || (opcode == OP_INQ);
  assign req_cnt    = (opcode == OP_SENSE) ? sense_cnt :
                      (opcode == OP_INQ)   ? inq_cnt   : 8'd0;
  // idx counts bytes already strobed; in WR_LO the current byte is not yet counted
  assign last_byte  = (({2'b00, idx} + 8'd1) == cnt);
  assign all_sent   = ({2'b00, idx} == cnt);
  assign unused_cmd = ^{COMMAND[95:40], COMMAND[31:8]};

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      gap_cnt  <= '0;
      is_sense <= 1'b0;
      ua_pend  <= (UNIT_ATTN != 0);
      ua_clr   <= 1'b0;
      STAT_GET <= 1'b0;
      STATUS   <= '0;
      CD_DATA  <= '0;
      CD_WR    <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      STAT_GET <= 1'b0;
      CD_WR    <= 1'b0;
      case (state)
        IDLE: begin
          if (COMM_SEND) begin
            BUSY     <= 1'b1;
            idx      <= '0;
            cnt      <= req_cnt;
            is_sense <= (opcode == OP_SENSE);
            ua_clr   <= (opcode == OP_SENSE) && (req_cnt != 8'd0);
            if (req_cnt == 8'd0) begin
              state    <= STAT;
              STAT_GET <= 1'b1;
              STATUS   <= is_data_op ? 8'h00 : 8'h02;
            end else if (CD_RDY) begin
              state   <= WR_HI;
              CD_WR   <= 1'b1;
              CD_DATA <= data_byte(opcode == OP_SENSE, ua_pend, 6'd0);
            end else begin
              state   <= GAP;
              gap_cnt <= '0;
            end
          end
        end
        WR_HI: state <= WR_LO;
        WR_LO: begin
          idx <= idx + 6'd1;
          if (BYTE_GAP > 0) begin
            state   <= GAP;
            gap_cnt <= 4'(BYTE_GAP - 1);
          end else if (last_byte) begin
            state    <= STAT;
            STAT_GET <= 1'b1;
            STATUS   <= 8'h00;
          end else if (CD_RDY) begin
            state   <= WR_HI;
            CD_WR   <= 1'b1;
            CD_DATA <= data_byte(is_sense, ua_pend, idx + 6'd1);
          end else begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        // GAP doubles as the wait state while the receiver holds CD_RDY low
        GAP: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else if (all_sent) begin
            state    <= STAT;
            STAT_GET <= 1'b1;
            STATUS   <= 8'h00;
          end else if (CD_RDY) begin
            state   <= WR_HI;
            CD_WR   <= 1'b1;
            CD_DATA <= data_byte(is_sense, ua_pend, idx);
          end
        end
        STAT: begin
          BUSY  <= 1'b0;
          state <= IDLE;
          if (ua_clr) ua_pend <= 1'b0;
          ua_clr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fake_cd_responder.sv
// Bench for fake_cd_responder: two instances (BYTE_GAP 0 and 2) share stimulus
// and are compared against a byte-image model of the drive's responses.
module tb_fake_cd_responder;

  localparam int SL    = 18;
  localparam int IL    = 36;
  localparam int DEPTH = 4096;
  localparam int LOGN  = 32768;

  logic        CLK;
  logic        RESn;
  logic [95:0] COMMAND;
  logic        COMM_SEND;
  logic        CD_RDY;
  logic [1:0]       stat_get;
  logic [1:0][7:0]  status;
  logic [1:0][7:0]  cd_data;
  logic [1:0]       cd_wr;
  logic [1:0]       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] got_data [2][DEPTH];
  int         got_cyc  [2][DEPTH];
  int         got_n    [2];
  logic [7:0] stat_val [2];
  int         stat_cyc [2];
  int         stat_n   [2];
  bit         busy_log [2][LOGN];
  bit [1:0]   wr_prev;
  logic       rdy_edge;

  logic [7:0] exp_data [64];
  int         exp_n;
  logic [7:0] exp_status;
  bit         ua_model;

  fake_cd_responder #(.BYTE_GAP(0)) u_gap0 (
    .CLK(CLK), .RESn(RESn), .COMMAND(COMMAND), .COMM_SEND(COMM_SEND), .CD_RDY(CD_RDY),
    .STAT_GET(stat_get[0]), .STATUS(status[0]), .CD_DATA(cd_data[0]),
    .CD_WR(cd_wr[0]), .BUSY(busy[0])
  );

  fake_cd_responder #(.BYTE_GAP(2)) u_gap2 (
    .CLK(CLK), .RESn(RESn), .COMMAND(COMMAND), .COMM_SEND(COMM_SEND), .CD_RDY(CD_RDY),
    .STAT_GET(stat_get[1]), .STATUS(status[1]), .CD_DATA(cd_data[1]),
    .CD_WR(cd_wr[1]), .BUSY(busy[1])
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    rdy_edge <= CD_RDY;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Record every strobe and status pulse; strobes must be single-cycle and start only with CD_RDY
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (cyc < LOGN) busy_log[i][cyc] = busy[i];
      if (cd_wr[i]) begin
        checkOutput($sformatf("dut%0d_wr_width", i), 32'(wr_prev[i]), 0);
        if (!wr_prev[i]) checkOutput($sformatf("dut%0d_wr_rdy", i), 32'(rdy_edge), 1);
        if (got_n[i] < DEPTH) begin
          got_data[i][got_n[i]] = cd_data[i];
          got_cyc[i][got_n[i]]  = cyc;
        end
        got_n[i]++;
      end
      if (stat_get[i]) begin
        stat_val[i] = status[i];
        stat_cyc[i] = cyc;
        stat_n[i]++;
      end
      wr_prev[i] = cd_wr[i];
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic buildExpected(input logic [7:0] op, input logic [7:0] alloc);
    int len;
    len        = 0;
    exp_n      = 0;
    exp_status = 8'h02;
    for (int k = 0; k < 64; k++) exp_data[k] = 8'h00;
    if (op == 8'h03) begin
      len          = SL;
      exp_data[0]  = 8'h70;
      exp_data[2]  = ua_model ? 8'h06 : 8'h02;
      exp_data[7]  = 8'(SL - 8);
      exp_data[12] = ua_model ? 8'h29 : 8'h3A;
    end else if (op == 8'h12) begin
      len = IL;
      for (int k = 8; k < IL; k++) exp_data[k] = 8'h20;
      exp_data[0] = 8'h05;
      exp_data[1] = 8'h80;
      exp_data[2] = 8'h02;
      exp_data[3] = 8'h02;
      exp_data[4] = 8'(IL - 5);
    end
    if (len > 0) begin
      exp_n      = (int'(alloc) < len) ? int'(alloc) : len;
      exp_status = 8'h00;
    end
  endtask

  task automatic checkResetOutputs();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("dut%0d_rst_stat_get", i), 32'(stat_get[i]), 0);
      checkOutput($sformatf("dut%0d_rst_status", i), 32'(status[i]), 0);
      checkOutput($sformatf("dut%0d_rst_cd_data", i), 32'(cd_data[i]), 0);
      checkOutput($sformatf("dut%0d_rst_cd_wr", i), 32'(cd_wr[i]), 0);
      checkOutput($sformatf("dut%0d_rst_busy", i), 32'(busy[i]), 0);
    end
  endtask

  // mode 0: CD_RDY always high (exact timing checked), 1: random, 2: low for 5 cycles mid-transfer
  task automatic applyStimulus(input logic [7:0] op, input logic [7:0] alloc,
                               input int mode, input bit inject);
    int n0, t, k, g, idx;
    int bd [2];
    int bs [2];
    logic [95:0] cmd;
    buildExpected(op, alloc);
    for (int i = 0; i < 2; i++) begin
      bd[i] = got_n[i];
      bs[i] = stat_n[i];
    end
    cmd = {$urandom(), $urandom(), $urandom()};
    cmd[7:0]   = op;
    cmd[39:32] = alloc;
    COMMAND   = cmd;
    COMM_SEND = 1'b1;
    n0 = cyc;
    tick();
    COMM_SEND = 1'b0;
    t = 0;
    while (!(stat_n[0] > bs[0] && stat_n[1] > bs[1]) && t < 3000) begin
      k = cyc - n0;
      case (mode)
        1:       CD_RDY = ($urandom_range(0, 3) != 0);
        2:       CD_RDY = !(k >= 6 && k < 11);
        default: CD_RDY = 1'b1;
      endcase
      if (inject && k == 2 && exp_n >= 2) begin
        cmd = {$urandom(), $urandom(), $urandom()};
        cmd[7:0] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h12;
        COMMAND   = cmd;
        COMM_SEND = 1'b1;
      end else begin
        COMM_SEND = 1'b0;
      end
      tick();
      t++;
    end
    checkOutput("cmd_done", 32'(stat_n[0] > bs[0] && stat_n[1] > bs[1]), 1);
    COMM_SEND = 1'b0;
    CD_RDY    = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 2; i++) begin
      g = (i == 0) ? 0 : 2;
      checkOutput($sformatf("gap%0d_op%0h_stat_count", g, op), 32'(stat_n[i] - bs[i]), 1);
      checkOutput($sformatf("gap%0d_op%0h_status", g, op), 32'(stat_val[i]), 32'(exp_status));
      checkOutput($sformatf("gap%0d_op%0h_byte_count", g, op), 32'(got_n[i] - bd[i]), 32'(exp_n));
      for (int b = 0; b < exp_n; b++) begin
        idx = bd[i] + b;
        if (idx < DEPTH) begin
          checkOutput($sformatf("gap%0d_op%0h_data%0d", g, op, b),
                      32'(got_data[i][idx]), 32'(exp_data[b]));
          if (mode == 0)
            checkOutput($sformatf("gap%0d_op%0h_time%0d", g, op, b),
                        32'(got_cyc[i][idx] - n0), 32'(1 + (2 + g) * b));
        end
      end
      if (exp_n > 0 && bd[i] + exp_n - 1 < DEPTH)
        checkOutput($sformatf("gap%0d_op%0h_stat_after_data", g, op),
                    32'(got_cyc[i][bd[i] + exp_n - 1] < stat_cyc[i]), 1);
      if (mode == 0)
        checkOutput($sformatf("gap%0d_op%0h_stat_time", g, op),
                    32'(stat_cyc[i] - n0), 32'(1 + (2 + g) * exp_n));
      if (stat_cyc[i] + 1 < LOGN) begin
        checkOutput($sformatf("gap%0d_busy_before", g), 32'(busy_log[i][n0]), 0);
        checkOutput($sformatf("gap%0d_busy_start", g), 32'(busy_log[i][n0 + 1]), 1);
        checkOutput($sformatf("gap%0d_busy_at_stat", g), 32'(busy_log[i][stat_cyc[i]]), 1);
        checkOutput($sformatf("gap%0d_busy_after", g), 32'(busy_log[i][stat_cyc[i] + 1]), 0);
      end
    end
    if (op == 8'h03 && exp_n > 0) ua_model = 1'b0;
  endtask

  task automatic resetMidTransfer();
    int bd0, bs0;
    logic [95:0] cmd;
    bd0 = got_n[0];
    bs0 = stat_n[0];
    cmd = {$urandom(), $urandom(), $urandom()};
    cmd[7:0]   = 8'h03;
    cmd[39:32] = 8'd18;
    COMMAND   = cmd;
    COMM_SEND = 1'b1;
    tick();
    COMM_SEND = 1'b0;
    for (int t = 0; t < 200 && (got_n[0] - bd0) < 8; t++) begin
      @(negedge CLK);
      #1;
    end
    checkOutput("reach_byte7", 32'((got_n[0] - bd0) >= 8), 1);
    #1;
    RESn = 1'b0;
    #1;
    checkResetOutputs();
    @(posedge CLK);
    #2;
    RESn = 1'b1;
    ua_model = 1'b1;
    repeat (3) tick();
    checkOutput("no_stat_on_reset", 32'(stat_n[0] - bs0), 0);
  endtask

  initial begin
    logic [7:0] op, alloc;
    int r;
    CLK       = 1'b0;
    RESn      = 1'b0;
    COMMAND   = '0;
    COMM_SEND = 1'b0;
    CD_RDY    = 1'b1;
    ua_model  = 1'b1;
    wr_prev   = '0;
    for (int i = 0; i < 2; i++) begin
      got_n[i]  = 0;
      stat_n[i] = 0;
    end
    #3;
    checkResetOutputs();
    repeat (2) @(posedge CLK);
    #2;
    RESn = 1'b1;
    tick();

    applyStimulus(8'h00, 8'h00, 0, 1'b0);
    applyStimulus(8'h03, 8'h00, 0, 1'b0);
    applyStimulus(8'h03, 8'h12, 0, 1'b0);
    applyStimulus(8'h03, 8'h12, 0, 1'b0);
    applyStimulus(8'h12, 8'hFF, 0, 1'b0);
    applyStimulus(8'h03, 8'h12, 2, 1'b1);
    resetMidTransfer();
    applyStimulus(8'h03, 8'h04, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 5);
      case (r)
        0:       op = 8'h00;
        1, 2:    op = 8'h03;
        3, 4:    op = 8'h12;
        default: begin
          op = 8'($urandom_range(0, 255));
          if (op == 8'h03 || op == 8'h12) op = 8'h1B;
        end
      endcase
      r = $urandom_range(0, 3);
      case (r)
        0:       alloc = 8'h00;
        1:       alloc = 8'($urandom_range(1, 8));
        2:       alloc = 8'($urandom_range(0, 255));
        default: alloc = 8'hFF;
      endcase
      applyStimulus(op, alloc, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
